bank_access_arbiter: RTL and testbench

- Shares one dual-port bank (separate write and read address ports, EN/WEN/REN strobes, 1-cycle registered read) between two clients, e.g. NTT butterfly engine (client 0) and host load/unload port (client 1).
- Arbitrates write slot and read slot independently each cycle, so one write and one read can issue in the same cycle.
- Round-robin fairness per slot, plus a per-client lock for uninterrupted bursts.
- Tags returned read data back to the issuing client.

---
 rtl/bank_access_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bank_access_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bank_access_arbiter.sv
// bank_access_arbiter: shares one dual-port bank (one write port, one read
// port with registered 1-cycle read) between two clients. Write and read
// slots are arbitrated independently with round-robin fairness and an
// optional per-client lock that keeps ownership of a slot for bursts.
// Read results are tagged back to the issuing client via c*_rvalid.
// Optional build macro: BANK_ARB_RDREG_EN adds one register stage on
// rdata/c*_rvalid (read latency 2 instead of 1).
`timescale 1ns/1ps
module bank_access_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic                  c0_lock,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_gnt,
  output logic                  c0_rvalid,
  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic                  c1_lock,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_gnt,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] bank_A1,
  output logic [ADDR_WIDTH-1:0] bank_A2,
  output logic [DATA_WIDTH-1:0] bank_D,
  output logic                  bank_WEN,
  output logic                  bank_REN,
  output logic                  bank_EN,
  input  logic [DATA_WIDTH-1:0] bank_Q
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_e;

  typedef struct packed {
    own_e       st;
    logic       ptr;
    logic [1:0] gnt;
  } slot_t;

  // One slot's arbitration step: grant vector plus next state/pointer.
  function automatic slot_t arb(input own_e st, input logic ptr,
                                input logic [1:0] req, input logic [1:0] lock);
    slot_t r;
    r.st  = st;
    r.ptr = ptr;
    r.gnt = '0;
    case (st)
      IDLE: begin
        if (req == 2'b11) r.gnt = ptr ? 2'b10 : 2'b01;
        else              r.gnt = req;
        if (r.gnt[0]) begin
          r.ptr = 1'b1;
          if (lock[0]) r.st = OWN0;
        end
        if (r.gnt[1]) begin
          r.ptr = 1'b0;
          if (lock[1]) r.st = OWN1;
        end
      end
      OWN0: begin
        r.gnt = {1'b0, req[0]};
        if (req[0]) r.ptr = 1'b1;
        if (!lock[0]) begin
          r.st  = IDLE;
          r.ptr = 1'b1;
        end
      end
      OWN1: begin
        r.gnt = {req[1], 1'b0};
        if (req[1]) r.ptr = 1'b0;
        if (!lock[1]) begin
          r.st  = IDLE;
          r.ptr = 1'b0;
        end
      end
      default: r.st = IDLE;
    endcase
    return r;
  endfunction

  own_e       wr_st_q, wr_st_d, rd_st_q, rd_st_d;
  logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] rv_q, rv_d;
  logic [1:0] wr_gnt, rd_gnt;
  slot_t      wr_n, rd_n;

  // Slot arbitration; grants are forced low while reset is asserted so all
  // outputs clear immediately without waiting for a clock edge.
  always_comb begin
    wr_n     = arb(wr_st_q, wr_ptr_q, {c1_req & c1_we, c0_req & c0_we},
                   {c1_lock, c0_lock});
    rd_n     = arb(rd_st_q, rd_ptr_q, {c1_req & ~c1_we, c0_req & ~c0_we},
                   {c1_lock, c0_lock});
    wr_st_d  = wr_n.st;
    wr_ptr_d = wr_n.ptr;
    rd_st_d  = rd_n.st;
    rd_ptr_d = rd_n.ptr;
    wr_gnt   = rst ? 2'b00 : wr_n.gnt;
    rd_gnt   = rst ? 2'b00 : rd_n.gnt;
    rv_d     = rd_gnt;
  end

  // Bank drive and client grants, muxed from the slot winners.
  always_comb begin
    c0_gnt   = wr_gnt[0] | rd_gnt[0];
    c1_gnt   = wr_gnt[1] | rd_gnt[1];
    bank_WEN = |wr_gnt;
    bank_REN = |rd_gnt;
    bank_EN  = bank_WEN | bank_REN;
    bank_A1  = '0;
    bank_D   = '0;
    bank_A2  = '0;
    if (wr_gnt[0]) begin
      bank_A1 = c0_addr;
      bank_D  = c0_wdata;
    end else if (wr_gnt[1]) begin
      bank_A1 = c1_addr;
      bank_D  = c1_wdata;
    end
    if (rd_gnt[0])      bank_A2 = c0_addr;
    else if (rd_gnt[1]) bank_A2 = c1_addr;
  end

  // Slot state, RR pointers and read-tag pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_st_q  <= IDLE;
      rd_st_q  <= IDLE;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rv_q     <= '0;
    end else begin
      wr_st_q  <= wr_st_d;
      rd_st_q  <= rd_st_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rv_q     <= rv_d;
    end
  end

`ifdef BANK_ARB_RDREG_EN
  logic [1:0]            rv2_q, rv2_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Extra return stage: capture bank_Q only when a read is actually returning.
  always_comb begin
    rv2_d   = rv_q;
    rdata_d = (|rv_q) ? bank_Q : '0;
  end

  // Registered read-return stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv2_q   <= '0;
      rdata_q <= '0;
    end else begin
      rv2_q   <= rv2_d;
      rdata_q <= rdata_d;
    end
  end

  assign c0_rvalid = rv2_q[0];
  assign c1_rvalid = rv2_q[1];
  assign rdata     = rdata_q;
`else
  // rdata follows bank_Q while a read returns and reads 0 otherwise, which
  // also gives the 0 value required during reset.
  assign c0_rvalid = rv_q[0];
  assign c1_rvalid = rv_q[1];
  assign rdata     = (|rv_q) ? bank_Q : '0;
`endif

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Directed, table-driven bench for bank_access_arbiter with a behavioural
// read-before-write bank model. Expected rvalid/rdata in the table are
// written for latency 1 and shifted when BANK_ARB_RDREG_EN is defined.
`timescale 1ns/1ps
module tb_bank_access_arbiter;
  localparam int AW = 7;
  localparam int DW = 256;
`ifdef BANK_ARB_RDREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic c0_req, c0_we, c0_lock, c1_req, c1_we, c1_lock;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
  logic [DW-1:0] rdata, bank_D, bank_Q;
  logic [AW-1:0] bank_A1, bank_A2;
  logic bank_WEN, bank_REN, bank_EN;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bank_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_lock(c0_lock), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid),
    .c1_req(c1_req), .c1_we(c1_we), .c1_lock(c1_lock), .c1_addr(c1_addr),
    .c1_wdata(c1_wdata), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid),
    .rdata(rdata), .bank_A1(bank_A1), .bank_A2(bank_A2), .bank_D(bank_D),
    .bank_WEN(bank_WEN), .bank_REN(bank_REN), .bank_EN(bank_EN),
    .bank_Q(bank_Q)
  );

  // Bank model: registered read, read-before-write on the same address.
  logic [DW-1:0] mem [128];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    bank_Q = '0;
  end
  always @(posedge clk) begin
    if (bank_EN && bank_REN) bank_Q <= mem[bank_A2];
    if (bank_EN && bank_WEN) mem[bank_A1] <= bank_D;
  end

  typedef struct {
    logic rst;
    logic r0, w0, l0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1, l1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic g0, g1, v0, v1; logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rs,
                     input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic g0, g1, v0, v1, input logic [DW-1:0] rd);
    vec_t v;
    v.rst = rs;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    c0_req = v.r0; c0_we = v.w0; c0_lock = v.l0; c0_addr = v.a0; c0_wdata = v.d0;
    c1_req = v.r1; c1_we = v.w1; c1_lock = v.l1; c1_addr = v.a1; c1_wdata = v.d1;
  endtask

  task automatic drive_idle();
    c0_req = 0; c0_we = 0; c0_lock = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_lock = 0; c1_addr = '0; c1_wdata = '0;
  endtask

  initial begin
    vec_t v;
    int j;
    logic ev0, ev1, ewen, eren;
    logic [AW-1:0] ea1, ea2;
    logic [DW-1:0] ed, erd;

    //   rst  r0 w0 l0 a0 d0        r1 w1 l1 a1 d1        g0 g1 v0 v1 rdata
    add(0,   1, 1, 0, 5, 'hA5,     0, 0, 0, 0, 0,        1, 0, 0, 0, 0);      // c0 write 5
    add(0,   1, 0, 0, 5, 0,        0, 0, 0, 0, 0,        1, 0, 0, 0, 0);      // c0 read 5
    add(0,   0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 1, 0, 'hA5);
    add(0,   1, 1, 0, 1, 'h101,    1, 1, 0, 2, 'h202,    0, 1, 0, 0, 0);      // wr ptr at c1
    add(0,   1, 1, 0, 1, 'h101,    1, 1, 0, 3, 'h22,     1, 0, 0, 0, 0);
    add(0,   0, 0, 0, 0, 0,        1, 1, 0, 3, 'h22,     0, 1, 0, 0, 0);
    add(1,   0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0, 0, 0);      // reset
    add(0,   1, 0, 0, 1, 0,        1, 0, 0, 2, 0,        1, 0, 0, 0, 0);      // alternating reads
    add(0,   1, 0, 0, 1, 0,        1, 0, 0, 2, 0,        0, 1, 1, 0, 'h101);
    add(0,   1, 0, 0, 1, 0,        1, 0, 0, 2, 0,        1, 0, 0, 1, 'h202);
    add(0,   1, 0, 0, 1, 0,        1, 0, 0, 2, 0,        0, 1, 1, 0, 'h101);
    add(0,   0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0, 1, 'h202);
    add(0,   1, 1, 0, 3, 'h11,     1, 0, 0, 3, 0,        1, 1, 0, 0, 0);      // same-addr wr+rd
    add(0,   0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0, 1, 'h22);
    add(0,   1, 0, 0, 3, 0,        0, 0, 0, 0, 0,        1, 0, 0, 0, 0);
    add(0,   0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 1, 0, 'h11);
    add(0,   1, 0, 0, 1, 0,        1, 0, 1, 2, 0,        0, 1, 0, 0, 0);      // c1 locked burst
    add(0,   1, 0, 0, 1, 0,        1, 0, 1, 2, 0,        0, 1, 0, 1, 'h202);
    add(0,   1, 0, 0, 1, 0,        1, 0, 1, 2, 0,        0, 1, 0, 1, 'h202);
    add(0,   1, 0, 0, 1, 0,        1, 0, 1, 2, 0,        0, 1, 0, 1, 'h202);
    add(0,   1, 0, 0, 1, 0,        0, 0, 0, 0, 0,        0, 0, 0, 1, 'h202);  // lock drops
    add(0,   1, 0, 0, 1, 0,        0, 0, 0, 0, 0,        1, 0, 0, 0, 0);
    add(0,   0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 1, 0, 'h101);
    add(0,   0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0, 0, 0);
    add(0,   0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0, 0, 0);

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_c0_gnt", c0_gnt, 0);
    chk("rst_c1_rvalid", c1_rvalid, 0);
    chk("rst_bank_EN", bank_EN, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      v = tbl[i];
      drive(v);
      #3;
      j   = i - (LAT - 1);
      ev0 = (j >= 0 && !v.rst) ? tbl[j].v0 : 1'b0;
      ev1 = (j >= 0 && !v.rst) ? tbl[j].v1 : 1'b0;
      erd = (j >= 0) ? tbl[j].rd : '0;
      ewen = (v.g0 & v.w0) | (v.g1 & v.w1);
      eren = (v.g0 & ~v.w0) | (v.g1 & ~v.w1);
      ea1 = (v.g0 & v.w0) ? v.a0 : ((v.g1 & v.w1) ? v.a1 : '0);
      ed  = (v.g0 & v.w0) ? v.d0 : ((v.g1 & v.w1) ? v.d1 : '0);
      ea2 = (v.g0 & ~v.w0) ? v.a0 : ((v.g1 & ~v.w1) ? v.a1 : '0);
      chk($sformatf("v%0d_c0_gnt", i), c0_gnt, v.g0);
      chk($sformatf("v%0d_c1_gnt", i), c1_gnt, v.g1);
      chk($sformatf("v%0d_c0_rvalid", i), c0_rvalid, ev0);
      chk($sformatf("v%0d_c1_rvalid", i), c1_rvalid, ev1);
      if (ev0 || ev1 || v.rst) chk($sformatf("v%0d_rdata", i), rdata, v.rst ? '0 : erd);
      chk($sformatf("v%0d_bank_WEN", i), bank_WEN, ewen);
      chk($sformatf("v%0d_bank_REN", i), bank_REN, eren);
      chk($sformatf("v%0d_bank_EN", i), bank_EN, ewen | eren);
      chk($sformatf("v%0d_bank_A1", i), bank_A1, ea1);
      chk($sformatf("v%0d_bank_D", i), bank_D, ed);
      chk($sformatf("v%0d_bank_A2", i), bank_A2, ea2);
    end

    // Reset one cycle after a locked read grant: read dropped, lock released.
    @(posedge clk);
    #1;
    drive_idle();
    c1_req = 1; c1_lock = 1; c1_addr = 2;
    #3;
    chk("seq_c1_lock_gnt", c1_gnt, 1);
    @(posedge clk);
    #1;
    c0_req = 1; c0_addr = 1;
    rst = 1'b1;
    #1;
    chk("seq_rst_c0_gnt", c0_gnt, 0);
    chk("seq_rst_c1_gnt", c1_gnt, 0);
    chk("seq_rst_c1_rvalid", c1_rvalid, 0);
    chk("seq_rst_c0_rvalid", c0_rvalid, 0);
    chk("seq_rst_bank_EN", bank_EN, 0);
    chk("seq_rst_bank_REN", bank_REN, 0);
    chk("seq_rst_rdata", rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    chk("seq_post_rst_c0_gnt", c0_gnt, 1);
    chk("seq_post_rst_c1_gnt", c1_gnt, 0);
    chk("seq_post_rst_c1_rvalid", c1_rvalid, 0);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      drive_idle();
      #3;
      chk($sformatf("seq_ret%0d_c0_rvalid", k), c0_rvalid, (k == LAT) ? 1'b1 : 1'b0);
      chk($sformatf("seq_ret%0d_c1_rvalid", k), c1_rvalid, 0);
    end
    chk("seq_ret_rdata", rdata, 'h101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
